// File: rtl/ecc_pkg.sv
// Shared types and constants for the (16,11) SECDED decode unit.
// Optional error counters are built only when ECC_STATS_EN is defined.
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WR_LO,
        WR_HI,
        DONE
    } ecc_state_t;

    typedef logic [1:0] ecc_status_t;

    localparam ecc_status_t ECC_CLEAN = 2'b00;
    localparam ecc_status_t ECC_CORR  = 2'b01;
    localparam ecc_status_t ECC_DBL   = 2'b10;

    // Codeword position of each data bit; element 0 is d0.
    localparam logic [10:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
        4'd9,  4'd7,  4'd6,  4'd5,  4'd3
    };

    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        logic [10:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/ecc_decode_unit_if.sv
// Register-file side of the decode unit: two combinational read ports
// and one granted write port.
interface ecc_decode_unit_if #(
    parameter int PW = 4
) ();

    logic [PW-1:0] rd_addrA;
    logic [PW-1:0] rd_addrB;
    logic [7:0]    datA_in;
    logic [7:0]    datB_in;
    logic          wr_gnt;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output rd_addrA, rd_addrB, wr_en, wr_addr, wr_data,
        input  datA_in, datB_in, wr_gnt
    );

    modport slave (
        input  rd_addrA, rd_addrB, wr_en, wr_addr, wr_data,
        output datA_in, datB_in, wr_gnt
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Syndrome (XOR of set-bit indices 1..15) and overall parity of a
// 16-bit extended-Hamming codeword.
module hamming_syndrome (
    input  logic [15:0] cw,
    output logic [3:0]  s,
    output logic        p
);

    always_comb begin
        // NOTE: default first so every path assigns s and no latch is inferred.
        s = '0;
        for (int i = 1; i < 16; i++) begin
            if (cw[i]) s = s ^ 4'(i);
        end
    end

    assign p = ^cw;

endmodule

// File: rtl/ecc_decode_unit.sv
// SECDED decode/correct engine between register-file reads and write port.
// Define ECC_STATS_EN to build the saturating single/double error counters.
module ecc_decode_unit
    import ecc_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PW-1:0]     src_hi,
    input  logic [PW-1:0]     src_lo,
    input  logic [PW-1:0]     dst_hi,
    input  logic [PW-1:0]     dst_lo,
    ecc_decode_unit_if.master rf,
    output logic              busy,
    output logic              done,
    output ecc_status_t       status,
    output logic [7:0]        sgl_cnt,
    output logic [7:0]        dbl_cnt
);

    ecc_state_t    state;
    logic [PW-1:0] dst_hi_q;
    logic [PW-1:0] dst_lo_q;
    logic [15:0]   cw_q;
    logic [7:0]    hi_q;
    ecc_status_t   res_status;

    logic [3:0]    syn;
    logic          par;
    logic [15:0]   cw_fix;
    ecc_status_t   st_c;
    logic [10:0]   d_c;

    hamming_syndrome u_syn (
        .cw (cw_q),
        .s  (syn),
        .p  (par)
    );

    // Odd overall parity means one flipped bit; syndrome 0 puts it at bit 0.
    always_comb begin
        cw_fix = cw_q;
        st_c   = ECC_CLEAN;
        if (par) begin
            st_c = ECC_CORR;
            if (syn != 4'd0) cw_fix[syn] = ~cw_q[syn];
        end else if (syn != 4'd0) begin
            st_c = ECC_DBL;
        end
    end

    assign d_c = extract_data(cw_fix);

    // NOTE: registered state uses non-blocking assignments only, so every
    // branch sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rf.rd_addrA <= '0;
            rf.rd_addrB <= '0;
            rf.wr_en    <= 1'b0;
            rf.wr_addr  <= '0;
            rf.wr_data  <= '0;
            dst_hi_q    <= '0;
            dst_lo_q    <= '0;
            cw_q        <= '0;
            hi_q        <= '0;
            res_status  <= ECC_CLEAN;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ECC_CLEAN;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rf.rd_addrA <= src_hi;
                        rf.rd_addrB <= src_lo;
                        dst_hi_q    <= dst_hi;
                        dst_lo_q    <= dst_lo;
                        busy        <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    cw_q  <= {rf.datA_in, rf.datB_in};
                    state <= CALC;
                end
                CALC: begin
                    hi_q       <= {st_c, 3'b000, d_c[10:8]};
                    res_status <= st_c;
                    rf.wr_en   <= 1'b1;
                    rf.wr_addr <= dst_lo_q;
                    rf.wr_data <= d_c[7:0];
                    state      <= WR_LO;
                end
                WR_LO: begin
                    if (rf.wr_gnt) begin
                        rf.wr_addr <= dst_hi_q;
                        rf.wr_data <= hi_q;
                        state      <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (rf.wr_gnt) begin
                        rf.wr_en <= 1'b0;
                        done     <= 1'b1;
                        status   <= res_status;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ECC_STATS_EN
    logic [7:0] sgl_q;
    logic [7:0] dbl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sgl_q <= '0;
            dbl_q <= '0;
        end else if (state == WR_HI && rf.wr_gnt) begin
            if (res_status == ECC_CORR && sgl_q != 8'hFF) sgl_q <= sgl_q + 8'd1;
            if (res_status == ECC_DBL && dbl_q != 8'hFF) dbl_q <= dbl_q + 8'd1;
        end
    end

    assign sgl_cnt = sgl_q;
    assign dbl_cnt = dbl_q;
`else
    assign sgl_cnt = '0;
    assign dbl_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_decode_unit.sv
// Randomized self-checking bench for ecc_decode_unit against an
// encode-and-inject reference model; honours ECC_STATS_EN like the RTL.
module tb_ecc_decode_unit;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] src_hi, src_lo, dst_hi, dst_lo;
    logic          busy, done;
    logic [1:0]    status;
    logic [7:0]    sgl_cnt, dbl_cnt;
    logic          gnt;

    logic [7:0]    regs [16];
    logic          poke_en;
    logic [PW-1:0] poke_addr;
    logic [7:0]    poke_data;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sgl = 0;
    int exp_dbl = 0;

    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    ecc_decode_unit_if #(.PW(PW)) rf_if ();

    ecc_decode_unit #(.PW(PW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .src_hi  (src_hi),
        .src_lo  (src_lo),
        .dst_hi  (dst_hi),
        .dst_lo  (dst_lo),
        .rf      (rf_if),
        .busy    (busy),
        .done    (done),
        .status  (status),
        .sgl_cnt (sgl_cnt),
        .dbl_cnt (dbl_cnt)
    );

    always #5 clk = ~clk;

    // Register-file model: combinational reads, granted writes, bench pokes.
    assign rf_if.datA_in = regs[rf_if.rd_addrA];
    assign rf_if.datB_in = regs[rf_if.rd_addrB];
    assign rf_if.wr_gnt  = gnt;

    always @(posedge clk) begin
        if (rf_if.wr_en && rf_if.wr_gnt) regs[rf_if.wr_addr] <= rf_if.wr_data;
        if (poke_en) regs[poke_addr] <= poke_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [PW-1:0] a, input logic [7:0] v);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = v;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        logic        pb;
        cw = '0;
        for (int i = 0; i < 11; i++) cw[pos[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            pb = 1'b0;
            for (int j = 1; j < 16; j++) if ((j >> k) & 1) pb ^= cw[j];
            cw[1 << k] = pb;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] raw_data(input logic [15:0] cw);
        logic [10:0] d;
        for (int i = 0; i < 11; i++) d[i] = cw[pos[i]];
        return d;
    endfunction

    task automatic note_status(input logic [1:0] st);
`ifdef ECC_STATS_EN
        if (st == 2'b01 && exp_sgl < 255) exp_sgl++;
        if (st == 2'b10 && exp_dbl < 255) exp_dbl++;
`endif
    endtask

    task automatic do_decode(input logic [15:0] cw,
                             input logic [PW-1:0] sh, sl, dh, dl,
                             input int stall,
                             input logic [7:0] e_lo, e_hi, input logic [1:0] e_st);
        int c;
        int dc;
        poke(sh, cw[15:8]);
        poke(sl, cw[7:0]);
        src_hi = sh; src_lo = sl; dst_hi = dh; dst_lo = dl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c  = 1;
        dc = -1;
        while (c <= 24) begin
            if (c == 1) begin
                check("busy_read", busy, 1);
                check("rd_addrA", rf_if.rd_addrA, sh);
                check("rd_addrB", rf_if.rd_addrB, sl);
            end
            if (c == 3) begin
                check("wr_lo_en", rf_if.wr_en, 1);
                check("wr_lo_addr", rf_if.wr_addr, dl);
                check("wr_lo_data", rf_if.wr_data, e_lo);
                if (stall > 0) begin
                    gnt = 1'b0;
                    for (int s = 0; s < stall; s++) begin
                        start = (s == 1);
                        if (s == 1) begin
                            src_hi = ~sh; src_lo = ~sl; dst_hi = ~dh; dst_lo = ~dl;
                        end
                        @(posedge clk);
                        #1;
                        c++;
                        start = 1'b0;
                        check("stall_en", rf_if.wr_en, 1);
                        check("stall_addr", rf_if.wr_addr, dl);
                        check("stall_data", rf_if.wr_data, e_lo);
                    end
                    gnt = 1'b1;
                end
            end
            if (c == 4 + stall) begin
                check("wr_hi_en", rf_if.wr_en, 1);
                check("wr_hi_addr", rf_if.wr_addr, dh);
                check("wr_hi_data", rf_if.wr_data, e_hi);
            end
            if (done) begin
                dc = c;
                break;
            end
            @(posedge clk);
            #1;
            c++;
        end
        check("done_cycle", dc, 5 + stall);
        note_status(e_st);
        check("status", status, e_st);
        check("wr_en_off", rf_if.wr_en, 0);
        check("sgl_cnt", sgl_cnt, exp_sgl);
        check("dbl_cnt", dbl_cnt, exp_dbl);
        if (dl != dh) check("mem_lo", regs[dl], e_lo);
        check("mem_hi", regs[dh], e_hi);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic random_decode(input int nflip, input int stall);
        logic [10:0]   d, dd;
        logic [15:0]   cw;
        logic [1:0]    st;
        logic [PW-1:0] sh, sl;
        int            b0, b1;
        d  = 11'($urandom);
        cw = encode(d);
        b0 = $urandom_range(0, 15);
        b1 = (b0 + $urandom_range(1, 15)) % 16;
        if (nflip >= 1) cw[b0] = ~cw[b0];
        if (nflip == 2) cw[b1] = ~cw[b1];
        st = (nflip == 0) ? 2'b00 : (nflip == 1) ? 2'b01 : 2'b10;
        dd = (nflip == 2) ? raw_data(cw) : d;
        sh = PW'($urandom);
        sl = sh ^ PW'($urandom_range(1, 15));
        do_decode(cw, sh, sl, PW'($urandom), PW'($urandom), stall,
                  dd[7:0], {st, 3'b000, dd[10:8]}, st);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; gnt = 1'b1; poke_en = 1'b0;
        poke_addr = '0; poke_data = '0;
        src_hi = '0; src_lo = '0; dst_hi = '0; dst_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_wr_en", rf_if.wr_en, 0);
        check("rst_wr_addr", rf_if.wr_addr, 0);
        check("rst_wr_data", rf_if.wr_data, 0);
        check("rst_rd_addrA", rf_if.rd_addrA, 0);
        check("rst_sgl", sgl_cnt, 0);
        check("rst_dbl", dbl_cnt, 0);
        reset = 1'b0;

        do_decode(16'h0000, 4'd1, 4'd2, 4'd3, 4'd4, 0, 8'h00, 8'h00, 2'b00);
        do_decode(16'h0008, 4'd5, 4'd6, 4'd7, 4'd8, 0, 8'h00, 8'h40, 2'b01);
        do_decode(16'h0001, 4'd9, 4'd10, 4'd11, 4'd12, 0, 8'h00, 8'h40, 2'b01);
        do_decode(16'h0018, 4'd13, 4'd14, 4'd15, 4'd0, 0, 8'h01, 8'h80, 2'b10);
        // Overlapping source/destination, then a shared destination.
        do_decode(16'h0018, 4'd2, 4'd3, 4'd3, 4'd2, 0, 8'h01, 8'h80, 2'b10);
        do_decode(16'h0008, 4'd4, 4'd5, 4'd6, 4'd6, 0, 8'h00, 8'h40, 2'b01);
        random_decode(1, 3);

        // Reset while the high-byte write is pending.
        poke(4'd9, 8'hA5);
        poke(4'd10, 8'h00);
        poke(4'd11, 8'h18);
        src_hi = 4'd10; src_lo = 4'd11; dst_hi = 4'd9; dst_lo = 4'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_wr_hi", rf_if.wr_addr, 4'd9);
        gnt = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_sgl = 0;
        exp_dbl = 0;
        check("mid_rst_wr_en", rf_if.wr_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_status", status, 0);
        check("mid_rst_sgl", sgl_cnt, 0);
        check("mid_rst_dbl", dbl_cnt, 0);
        check("mid_rst_mem_hi", regs[9], 8'hA5);
        reset = 1'b0;
        gnt = 1'b1;

        for (int i = 0; i < 60; i++) random_decode($urandom_range(0, 2), $urandom_range(0, 2));
        for (int i = 0; i < 258; i++) random_decode(1, 0);
        random_decode(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_decode_unit.md
# ecc_decode_unit

SECDED correction engine for the (16,11) extended-Hamming codeword kept as two bytes in the 16-entry register file. On `start` it reads the high and low codeword bytes through the register file's two combinational read ports, computes syndrome and overall parity, and corrects a single-bit error. It then writes the 11-bit result plus a 2-bit status back through the register file's single write port under a grant handshake. It sits directly beside the register file: downstream of its read ports and upstream of its write port.

## Interface
- `PW`, default 4: register-file address width (16 entries).
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request decode; sampled only in IDLE
- `src_hi`, `src_lo`  in  PW  register addresses of the codeword high and low bytes
- `dst_hi`, `dst_lo`  in  PW  register addresses for the result bytes
- `rd_addrA`, `rd_addrB`  out  PW  to the register-file read ports (A = high byte, B = low byte)
- `datA_in`, `datB_in`  in  8  register-file read data
- `wr_gnt`  in  1  write port granted this cycle
- `wr_en`  out  1  write request / enable
- `wr_addr`  out  PW  write address
- `wr_data`  out  8  write data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `status`  out  2  last result: 00 clean, 01 corrected, 10 double error, 11 unused
- `sgl_cnt`, `dbl_cnt`  out  8  error counters (see Configuration)

## Operation
- Codeword `cw[15:0] = {datA_in, datB_in}`. Bit 0 is overall parity. Bits 1, 2, 4 and 8 are Hamming parity. Data `d[10:0]` sits at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15 (d0 = position 3, d10 = position 15).
- Syndrome `s[3:0]` = XOR of the indices i in 1..15 where `cw[i]=1`. Overall parity `p` = XOR of all 16 bits.
- Classification:
  - s=0, p=0: clean, status 00.
  - s≠0, p=1: flip `cw[s]`, status 01.
  - s=0, p=1: only bit 0 is wrong, data unchanged, status 01.
  - s≠0, p=0: double error, data extracted uncorrected, status 10.
- Result bytes: `lo = d[7:0]`, `hi = {status, 3'b000, d[10:8]}`.
- FSM states, one cycle each unless stalled:
  - IDLE → READ on `start`. Latch all four addresses on that edge.
  - READ: drive `rd_addrA`/`rd_addrB` with the latched source addresses. Capture `cw` at the end of the cycle.
  - CALC: register the corrected data and status.
  - WR_LO: `wr_en=1`, `wr_addr=dst_lo`, `wr_data=lo`. Advance only on a cycle with `wr_gnt=1`.
  - WR_HI: same, for `dst_hi`/`hi`.
  - DONE: `done=1`, update the `status` output. Then go to IDLE.
- `wr_en` is high only in WR_LO and WR_HI. While `wr_gnt=0`, `wr_en`, `wr_addr` and `wr_data` hold stable.
- `start` while busy is ignored. Addresses are not re-latched.
- `dst_hi == dst_lo`: both writes occur; the high byte is the final value.
- Source and destination may overlap. The codeword is captured in READ, so later writes do not affect the result.

## Timing
- Reset values: state IDLE; `rd_addrA`, `rd_addrB`, `wr_addr` 0; `wr_data` 0; `wr_en`, `busy`, `done` 0; `status` 00; counters 0.
- With `wr_gnt` held high: `start` sampled at edge 0 gives READ in cycle 1, CALC in 2, WR_LO in 3, WR_HI in 4, DONE in 5 (`done` pulse), IDLE in 6. Latency is 5 cycles from start to done, plus one cycle per stalled grant cycle.
- A register-file write issued in WR_HI is visible to any read from cycle 5 onward.
- Reset asserted in any state returns the FSM to IDLE at the next edge and forces `wr_en=0`. A pending write is dropped.
- Throughput: one decode per 6 cycles; a new `start` may be sampled in the IDLE cycle after `done`.

## Configuration
- `ECC_STATS_EN` defined: `sgl_cnt` and `dbl_cnt` increment in DONE for status 01 and status 10 respectively. Both saturate at 0xFF and clear on reset.
- `ECC_STATS_EN` undefined: no counter registers are built, and `sgl_cnt`/`dbl_cnt` are tied to 0.

## Structure
- Package `ecc_pkg` holds:
  - the state enum `ecc_state_t` (IDLE, READ, CALC, WR_LO, WR_HI, DONE);
  - the status typedef `ecc_status_t` and constants `ECC_CLEAN`, `ECC_CORR`, `ECC_DBL`;
  - the data-position constant array.
- Sub-module `hamming_syndrome`: combinational; takes `cw[15:0]` and outputs `s[3:0]` and `p`. Instantiated once, in CALC.

## Test plan
- Clean: `cw=0x0000`, gnt high → lo 0x00, hi 0x00, status 00, `done` in cycle 5.
- Single data error: `cw=0x0008` → s=3, corrected; lo 0x00, hi 0x40, status 01; `sgl_cnt` 1 with `ECC_STATS_EN`.
- Bit 0 only: `cw=0x0001` → lo 0x00, hi 0x40, status 01.
- Double error: `cw=0x0018` → s=7, p=0; lo 0x01, hi 0x80, status 10; `dbl_cnt` 1 with `ECC_STATS_EN`.
- Grant stall: `wr_gnt` low for 3 cycles in WR_LO → `wr_en`, `wr_addr` and `wr_data` stay stable; `done` in cycle 8; a `start` pulse during the stall is ignored.
- Reset in WR_HI: `wr_en` is 0 the next cycle, state is IDLE, `dst_hi` is unwritten, and `status` is 00.
